// File: rtl/input_fifo_handshake_if.sv
// Handshake and read-side bundle between the upstream output arbiter,
// the input FIFO, and the local output arbiters.
interface input_fifo_handshake_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] RX;
    logic                  DRTS;
    logic                  read_en_N;
    logic                  read_en_E;
    logic                  read_en_W;
    logic                  read_en_S;
    logic                  read_en_L;
    logic                  CTS;
    logic [DATA_WIDTH-1:0] Data_out;
    logic                  empty;
    logic                  full;
    logic [PTR_W:0]        count;

    // FIFO side: receives flits and pop requests, reports CTS and status.
    modport slave (
        input  RX, DRTS, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
        output CTS, Data_out, empty, full, count
    );

    // Environment side: upstream sender plus the local output arbiters.
    modport master (
        output RX, DRTS, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
        input  CTS, Data_out, empty, full, count
    );
endinterface

// File: rtl/input_fifo_handshake.sv
// Router input port: answers upstream RTS with a one-cycle CTS pulse,
// captures the flit on the handshake cycle into a circular FIFO, and
// presents the head flit first-word fall-through to the output arbiters.
module input_fifo_handshake #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input logic                  clk,
    input logic                  rst,
    input_fifo_handshake_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      read_ptr;
    logic [PTR_W-1:0]      write_ptr;
    logic [PTR_W:0]        count;
    logic                  cts;

    logic empty;
    logic full;
    logic read_en;
    logic write_en;
    logic pop;
    logic cts_next;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign read_en  = bus.read_en_N | bus.read_en_E | bus.read_en_W |
                      bus.read_en_S | bus.read_en_L;
    // A CTS pulse that upstream did not answer is simply lost.
    assign write_en = bus.DRTS & cts;
    assign pop      = read_en & ~empty;
    // CTS drops for at least one cycle after every pulse, so the full check
    // always sees occupancy that already includes the previous write.
    assign cts_next = bus.DRTS & ~cts & ~full;

    // Control state: CTS, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            cts       <= 1'b0;
            read_ptr  <= '0;
            write_ptr <= '0;
            count     <= '0;
        end else begin
            cts <= cts_next;
            if (write_en) begin
                write_ptr <= write_ptr + PTR_ONE;
            end
            if (pop) begin
                read_ptr <= read_ptr + PTR_ONE;
            end
            case ({write_en, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Flit storage; not cleared by reset, but a flit arriving during reset is dropped.
    always_ff @(posedge clk) begin
        if (write_en && !rst) begin
            mem[write_ptr] <= bus.RX;
        end
    end

    assign bus.CTS      = cts;
    assign bus.Data_out = mem[read_ptr];
    assign bus.empty    = empty;
    assign bus.full     = full;
    assign bus.count    = count;
endmodule

// File: tb/tb_input_fifo_handshake.sv
// Self-checking bench for input_fifo_handshake: a queue scoreboard records
// every accepted flit and checks it against Data_out when it is popped.
module tb_input_fifo_handshake;
    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 4;

    logic clk;
    logic rst;

    input_fifo_handshake_if #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) bus ();

    input_fifo_handshake #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_WIDTH-1:0] sb[$];
    bit m_cts = 1'b0;
    int cts_pulses = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: predict from the inputs currently driven, clock, then compare.
    task automatic step(output bit wrote);
        bit rd;
        bit wr;
        bit pop;
        bit nc;
        logic [DATA_WIDTH-1:0] tmp;
        wrote = 1'b0;
        rd = bus.read_en_N | bus.read_en_E | bus.read_en_W | bus.read_en_S | bus.read_en_L;
        if (rst) begin
            sb.delete();
            m_cts = 1'b0;
        end else begin
            wr  = bus.DRTS && m_cts;
            pop = rd && (sb.size() != 0);
            nc  = bus.DRTS && !m_cts && (sb.size() != DEPTH);
            if (pop) begin
                check("pop_data", 64'(bus.Data_out), 64'(sb[0]));
                tmp = sb.pop_front();
            end
            if (wr) sb.push_back(bus.RX);
            wrote = wr;
            m_cts = nc;
        end
        @(posedge clk);
        #1;
        check("cts",   64'(bus.CTS),   64'(m_cts));
        check("count", 64'(bus.count), 64'(sb.size()));
        check("empty", 64'(bus.empty), 64'(sb.size() == 0));
        check("full",  64'(bus.full),  64'(sb.size() == DEPTH));
        if (sb.size() != 0) check("head", 64'(bus.Data_out), 64'(sb[0]));
        if (bus.CTS) cts_pulses++;
    endtask

    // Hold DRTS high until n flits starting at base have been accepted.
    task automatic fill(input int n, input logic [DATA_WIDTH-1:0] base);
        int got;
        bit w;
        got = 0;
        bus.DRTS = 1'b1;
        bus.RX   = base;
        for (int i = 0; i < 4 * n + 4 && got < n; i++) begin
            step(w);
            if (w) begin
                got++;
                bus.RX = base + DATA_WIDTH'(got);
            end
        end
        bus.DRTS = 1'b0;
        check("fill_done", 64'(got), 64'(n));
    endtask

    // Pulse the East read enable n times (one cycle high, one cycle low).
    task automatic drain_e(input int n);
        bit w;
        for (int i = 0; i < n; i++) begin
            bus.read_en_E = 1'b1;
            step(w);
            bus.read_en_E = 1'b0;
            step(w);
        end
    endtask

    initial begin
        bit w;
        rst = 1'b1;
        bus.RX = '0;
        bus.DRTS = 1'b0;
        bus.read_en_N = 1'b0;
        bus.read_en_E = 1'b0;
        bus.read_en_W = 1'b0;
        bus.read_en_S = 1'b0;
        bus.read_en_L = 1'b0;

        // Reset state
        step(w);
        step(w);
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_empty", 64'(bus.empty), 64'd1);
        check("rst_cts",   64'(bus.CTS),   64'd0);
        rst = 1'b0;
        step(w);

        // Single flit
        bus.DRTS = 1'b1;
        bus.RX   = 32'hA5A5_0001;
        step(w);
        check("single_cts_pulse", 64'(bus.CTS), 64'd1);
        step(w);
        check("single_empty", 64'(bus.empty), 64'd0);
        check("single_count", 64'(bus.count), 64'd1);
        check("single_data",  64'(bus.Data_out), 64'h0000_0000_A5A5_0001);
        check("single_cts_low", 64'(bus.CTS), 64'd0);
        bus.DRTS = 1'b0;
        drain_e(1);
        check("single_drained", 64'(bus.empty), 64'd1);

        // Fill to full (pointers start at 1, so this wraps)
        cts_pulses = 0;
        fill(4, 32'h1);
        check("fill_pulses", 64'(cts_pulses), 64'd4);
        check("fill_full",   64'(bus.full),   64'd1);
        check("fill_count",  64'(bus.count),  64'd4);
        bus.DRTS = 1'b1;
        bus.RX   = 32'hDEAD_BEEF;
        cts_pulses = 0;
        for (int i = 0; i < 10; i++) step(w);
        check("full_hold_pulses", 64'(cts_pulses), 64'd0);
        bus.DRTS = 1'b0;
        step(w);

        // Drain 1..4, then write and read 5,6,7
        drain_e(4);
        check("drain_empty", 64'(bus.empty), 64'd1);
        fill(3, 32'h5);
        check("wrap_count", 64'(bus.count), 64'd3);
        drain_e(3);
        check("wrap_empty", 64'(bus.empty), 64'd1);

        // Concurrent read and write at count=2
        fill(2, 32'h8);
        bus.DRTS = 1'b1;
        bus.RX   = 32'hA;
        step(w);
        check("conc_cts", 64'(bus.CTS), 64'd1);
        bus.read_en_L = 1'b1;
        step(w);
        bus.read_en_L = 1'b0;
        bus.DRTS = 1'b0;
        check("conc_count", 64'(bus.count), 64'd2);
        check("conc_head",  64'(bus.Data_out), 64'h9);
        step(w);

        // Multi-enable pop with count=2, then drain and empty read
        bus.read_en_N = 1'b1;
        bus.read_en_S = 1'b1;
        step(w);
        bus.read_en_N = 1'b0;
        bus.read_en_S = 1'b0;
        check("multi_count", 64'(bus.count), 64'd1);
        check("multi_head",  64'(bus.Data_out), 64'hA);
        bus.read_en_W = 1'b1;
        step(w);
        bus.read_en_W = 1'b0;
        bus.read_en_N = 1'b1;
        bus.read_en_S = 1'b1;
        step(w);
        step(w);
        bus.read_en_N = 1'b0;
        bus.read_en_S = 1'b0;
        check("empty_read_count", 64'(bus.count), 64'd0);
        check("empty_read_empty", 64'(bus.empty), 64'd1);
        fill(1, 32'h55);
        check("after_empty_read", 64'(bus.Data_out), 64'h55);
        drain_e(1);

        // Reset mid-handshake with count=3
        fill(3, 32'h20);
        bus.DRTS = 1'b1;
        bus.RX   = 32'h99;
        step(w);
        check("mid_cts", 64'(bus.CTS), 64'd1);
        check("mid_count", 64'(bus.count), 64'd3);
        rst = 1'b1;
        step(w);
        check("mid_rst_count", 64'(bus.count), 64'd0);
        check("mid_rst_empty", 64'(bus.empty), 64'd1);
        check("mid_rst_cts",   64'(bus.CTS),   64'd0);
        rst = 1'b0;
        bus.DRTS = 1'b0;
        step(w);
        check("mid_discard", 64'(bus.empty), 64'd1);
        fill(1, 32'h30);
        check("post_rst_head", 64'(bus.Data_out), 64'h30);
        drain_e(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
